// File: rtl/fir_interp.sv
// Polyphase interpolate-by-4 pulse-shaping FIR: 13-tap prototype padded to 16 taps, valid/ready on both sides.
// Optional sticky underrun output enabled with `define FIR_INTERP_UNDERRUN_EN.
module fir_interp #(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready
`ifdef FIR_INTERP_UNDERRUN_EN
  ,
  output logic                     underrun
`endif
);

  localparam int L      = 4;
  localparam int PH_W   = $clog2(L);
  localparam int COEF_W = 8;
  localparam int PROD_W = DIN_W + COEF_W;
  localparam int ACC_W  = PROD_W + 2;

  localparam logic signed [COEF_W-1:0] H [16] = '{
    8'sd2,   8'sd0,  -8'sd9, -8'sd10,
    8'sd20,  8'sd74,  8'sd102, 8'sd74,
    8'sd20, -8'sd10, -8'sd9,   8'sd0,
    8'sd2,   8'sd0,   8'sd0,   8'sd0
  };

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                    state_q, state_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic signed [DIN_W-1:0]   x_q [4];
  logic signed [DIN_W-1:0]   x_d [4];
  logic signed [DOUT_W-1:0]  dout_q, dout_d;
  logic                      in_acc;
  logic                      out_xfer;
  logic                      last_phase;

  // Phase p uses taps p, p+4, p+8, p+12 against x0..x3; sum is saturated to the output width.
  function automatic logic signed [DOUT_W-1:0] fir_phase(
    input logic [PH_W-1:0]       p,
    input logic signed [DIN_W-1:0] a0,
    input logic signed [DIN_W-1:0] a1,
    input logic signed [DIN_W-1:0] a2,
    input logic signed [DIN_W-1:0] a3
  );
    logic signed [PROD_W-1:0] m0, m1, m2, m3;
    logic signed [ACC_W-1:0]  acc;
    logic                     in_range;
    m0 = a0 * H[{2'b00, p}];
    m1 = a1 * H[{2'b01, p}];
    m2 = a2 * H[{2'b10, p}];
    m3 = a3 * H[{2'b11, p}];
    acc = ACC_W'(m0) + ACC_W'(m1) + ACC_W'(m2) + ACC_W'(m3);
    in_range = (&acc[ACC_W-1:DOUT_W-1]) || !(|acc[ACC_W-1:DOUT_W-1]);
    if (in_range)
      fir_phase = acc[DOUT_W-1:0];
    else if (acc[ACC_W-1])
      fir_phase = {1'b1, {(DOUT_W-1){1'b0}}};
    else
      fir_phase = {1'b0, {(DOUT_W-1){1'b1}}};
  endfunction

  assign last_phase = (phase_q == PH_W'(L - 1));
  assign in_acc     = din_valid && din_ready;
  assign out_xfer   = dout_valid && dout_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_acc) state_d = S_EMIT;
      S_EMIT: if (out_xfer && last_phase && !in_acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Input is only taken while idle or when the final phase is leaving this cycle, so no bubble between bursts.
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state_q)
      S_IDLE: din_ready = 1'b1;
      S_EMIT: begin
        dout_valid = 1'b1;
        din_ready  = last_phase && dout_ready;
      end
      default: ;
    endcase
  end

  assign dout = dout_q;

  always_comb begin
    phase_d = phase_q;
    dout_d  = dout_q;
    for (int i = 0; i < 4; i++) x_d[i] = x_q[i];
    if (in_acc) begin
      x_d[0]  = din;
      x_d[1]  = x_q[0];
      x_d[2]  = x_q[1];
      x_d[3]  = x_q[2];
      phase_d = '0;
      dout_d  = fir_phase('0, din, x_q[0], x_q[1], x_q[2]);
    end else if (out_xfer && !last_phase) begin
      phase_d = phase_q + PH_W'(1);
      dout_d  = fir_phase(phase_q + PH_W'(1), x_q[0], x_q[1], x_q[2], x_q[3]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      dout_q  <= '0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      phase_q <= phase_d;
      dout_q  <= dout_d;
      for (int i = 0; i < 4; i++) x_q[i] <= x_d[i];
    end
  end

`ifdef FIR_INTERP_UNDERRUN_EN
  logic seen_q, seen_d;
  logic underrun_q, underrun_d;

  always_comb begin
    seen_d     = seen_q || in_acc;
    underrun_d = underrun_q || ((state_q == S_IDLE) && dout_ready && seen_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`endif

endmodule
